pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 12 +
 rtl/pipe_ctrl_perf.sv | 23 ++
 rtl/pipe_ctrl.sv | 106 ++++++++++
 tb/tb_pipe_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared pipeline control types and defaults.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    localparam int DEF_DRAIN_CYCLES = 3;

    function automatic int drain_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pipe_ctrl_perf.sv
// pipe_ctrl_perf: wrapping stall/flush cycle counters.
module pipe_ctrl_perf #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + CNT_W'(stall);
            flush_cnt <= flush_cnt + CNT_W'(flush);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard stall, branch flush and halt/drain control for a 5-stage pipeline.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_Rs1,
    input  logic [4:0]       ID_Rs2,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_Rd,
    input  logic             EX_branch_taken,
    input  logic             halt_req,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Write,
    output logic             halt_ack,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int DW = drain_w(DRAIN_CYCLES);

    state_t          state, state_n;
    logic   [DW-1:0] cnt, cnt_n;
    logic            load_use;

    assign load_use = EX_MemRead && EX_Rd != 5'd0 && (EX_Rd == ID_Rs1 || EX_Rd == ID_Rs2);
    assign halt_ack = state == HALTED;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        PC_Write    = 1'b1;
        IF_ID_Write = 1'b1;
        ID_EX_Write = 1'b1;
        IF_ID_Flush = 1'b0;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (EX_branch_taken) begin
                        ID_EX_Write = 1'b0;
                        IF_ID_Flush = 1'b1;
                    end else if (load_use) begin
                        PC_Write    = 1'b0;
                        IF_ID_Write = 1'b0;
                        ID_EX_Write = 1'b0;
                    end else if (halt_req) begin
                        state_n = DRAIN;
                        cnt_n   = DW'(DRAIN_CYCLES - 1);
                    end
                end
                DRAIN: begin
                    // a taken branch still redirects the PC and holds the drain count
                    PC_Write    = EX_branch_taken;
                    IF_ID_Flush = EX_branch_taken;
                    IF_ID_Write = 1'b0;
                    ID_EX_Write = 1'b0;
                    if (!halt_req) begin
                        state_n = RUN;
                        cnt_n   = '0;
                    end else if (!EX_branch_taken) begin
                        state_n = (cnt == '0) ? HALTED : DRAIN;
                        cnt_n   = (cnt == '0) ? cnt : cnt - 1'b1;
                    end
                end
                HALTED: begin
                    PC_Write    = 1'b0;
                    IF_ID_Write = 1'b0;
                    ID_EX_Write = 1'b0;
                    state_n     = halt_req ? HALTED : RUN;
                end
                default: state_n = RUN;
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    pipe_ctrl_perf #(.CNT_W(CNT_W)) u_perf (
        .clk       (clk),
        .rst       (rst),
        .stall     (!PC_Write),
        .flush     (IF_ID_Flush),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: randomized and directed checks of pipe_ctrl against a behavioural model.
module tb_pipe_ctrl;

    localparam int D = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ID_Rs1, ID_Rs2, EX_Rd;
    logic        EX_MemRead, EX_branch_taken, halt_req;
    logic        PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, halt_ack;
    logic [31:0] stall_cnt, flush_cnt;

    int          checks = 0;
    int          failures = 0;

    bit          m_drain, m_halted;
    int          m_done;
    logic [31:0] m_stall, m_flush;

    pipe_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .ID_Rs1          (ID_Rs1),
        .ID_Rs2          (ID_Rs2),
        .EX_MemRead      (EX_MemRead),
        .EX_Rd           (EX_Rd),
        .EX_branch_taken (EX_branch_taken),
        .halt_req        (halt_req),
        .PC_Write        (PC_Write),
        .IF_ID_Write     (IF_ID_Write),
        .IF_ID_Flush     (IF_ID_Flush),
        .ID_EX_Write     (ID_EX_Write),
        .halt_ack        (halt_ack),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic drive(input bit br, input bit mr, input int rd, input int rs1, input int rs2, input bit hr);
        EX_branch_taken = br;
        EX_MemRead      = mr;
        EX_Rd           = 5'(rd);
        ID_Rs1          = 5'(rs1);
        ID_Rs2          = 5'(rs2);
        halt_req        = hr;
    endtask

    task automatic step(input string name);
        bit       lu;
        logic [4:0] exp, got;
        lu = EX_MemRead && EX_Rd != 0 && (EX_Rd == ID_Rs1 || EX_Rd == ID_Rs2);
        if (m_halted)             exp = 5'b00001;
        else if (m_drain)         exp = {EX_branch_taken, 2'b00, EX_branch_taken, 1'b0};
        else if (EX_branch_taken) exp = 5'b11010;
        else if (lu)              exp = 5'b00000;
        else                      exp = 5'b11100;
        #2;
        got = {PC_Write, IF_ID_Write, ID_EX_Write, IF_ID_Flush, halt_ack};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: {pc,ifid,idex,flush,ack} got %b exp %b", name, got, exp);
        end
        m_stall += 32'(!exp[4]);
        m_flush += 32'(exp[1]);
        @(posedge clk);
        #1;
        if (m_halted) m_halted = halt_req;
        else if (m_drain) begin
            if (!halt_req) m_drain = 0;
            else if (!EX_branch_taken) begin
                m_done++;
                if (m_done == D) begin
                    m_drain  = 0;
                    m_halted = 1;
                end
            end
        end else if (!EX_branch_taken && !lu && halt_req) begin
            m_drain = 1;
            m_done  = 0;
        end
    endtask

    task automatic check_cnt(input string name);
        logic [31:0] es, ef;
`ifdef PIPE_CTRL_PERF_EN
        es = m_stall;
        ef = m_flush;
`else
        es = 0;
        ef = 0;
`endif
        checks++;
        if (stall_cnt !== es || flush_cnt !== ef) begin
            failures++;
            $display("FAIL %s: stall_cnt=%0d flush_cnt=%0d exp %0d %0d", name, stall_cnt, flush_cnt, es, ef);
        end
    endtask

    task automatic test_reset(input string name);
        rst = 1'b1;
        #2;
        checks++;
        if ({PC_Write, IF_ID_Write, ID_EX_Write, IF_ID_Flush} !== 4'b1110) begin
            failures++;
            $display("FAIL %s_outputs: got %b exp 1110", name, {PC_Write, IF_ID_Write, ID_EX_Write, IF_ID_Flush});
        end
        @(posedge clk);
        #1;
        m_drain = 0; m_halted = 0; m_done = 0; m_stall = 0; m_flush = 0;
        checks++;
        if (halt_ack !== 1'b0) begin
            failures++;
            $display("FAIL %s_ack: got %b exp 0", name, halt_ack);
        end
        check_cnt({name, "_cnt"});
        rst = 1'b0;
    endtask

    task automatic test_load_use();
        drive(0, 1, 5, 3, 5, 0); step("load_use_stall");
        drive(0, 0, 5, 3, 5, 0); step("load_use_release");
        drive(0, 1, 7, 7, 1, 0); step("load_use_rs1");
        drive(0, 1, 0, 0, 0, 0); step("load_x0_no_stall");
        drive(0, 0, 4, 4, 4, 0); step("no_memread_no_stall");
    endtask

    task automatic test_branch_priority();
        drive(1, 1, 5, 5, 5, 1); step("branch_over_all");
        drive(0, 0, 0, 0, 0, 0); step("branch_stays_run");
    endtask

    task automatic test_halt();
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < D + 3; i++) step("halt_seq");
        drive(0, 0, 0, 0, 0, 0);
        step("halt_release_ack");
        step("halt_release_run");
    endtask

    task automatic test_abort_and_reset();
        drive(0, 0, 0, 0, 0, 1);
        step("abort_run");
        step("abort_drain1");
        drive(0, 0, 0, 0, 0, 0);
        step("abort_drain2");
        step("abort_back_run");
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < D + 2; i++) step("to_halted");
        test_reset("reset_in_halted");
        drive(0, 0, 0, 0, 0, 0);
        step("after_reset_run");
    endtask

    task automatic test_drain_branch();
        drive(0, 0, 0, 0, 0, 1);
        step("db_run");
        step("db_drain");
        drive(1, 0, 0, 0, 0, 1); step("db_branch");
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < D + 1; i++) step("db_rest");
        drive(0, 0, 0, 0, 0, 0);
        step("db_release");
        step("db_run_again");
    endtask

    task automatic test_perf();
        test_reset("perf_reset");
        drive(0, 1, 5, 0, 5, 0); step("perf_load_use");
        drive(1, 0, 0, 0, 0, 0); step("perf_branch");
        drive(0, 0, 0, 0, 0, 0); step("perf_idle");
        check_cnt("perf_counts");
    endtask

    task automatic test_random();
        bit hr = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) hr = !hr;
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), hr);
            step("random");
        end
        check_cnt("random_counts");
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        test_reset("reset");
        test_load_use();
        test_branch_priority();
        test_halt();
        test_abort_and_reset();
        test_drain_branch();
        test_perf();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
